baccarat_match_scheduler: RTL
=============================

Name: baccarat_match_scheduler

Overview:
- Sequences repeated rounds of the baccarat round engine into a best-of match.
- Holds the engine in reset until a match is requested, then releases it.
- Tallies each round's outcome from the engine's endround and win lights, and stops the engine when a side reaches the target wins or the round limit is hit.
- Sits between the player push-button/switch inputs and the round engine; drives the match-result LEDs and the tally displays.

Parameters:
- WINS_TO_MATCH, 3: round wins needed to take the match (1..MAX_ROUNDS).
- MAX_ROUNDS, 9: hard round limit per match; the match ends when it is reached.
- CNT_W, 4: width of every tally counter. Requires MAX_ROUNDS <= 2^CNT_W - 1.

Ports:
- slow_clock  in  1  system clock; all state updates on posedge.
- resetb  in  1  asynchronous active-low reset.
- start_match  in  1  level request to begin a new match; sampled each posedge.
- abort  in  1  level request to abandon the current match.
- endround  in  1  from round engine, high for one engine period at round end.
- player_win_light  in  1  from round engine, valid while endround is high.
- dealer_win_light  in  1  from round engine, valid while endround is high; both lights high means a tie.
- round_resetb  out  1  active-low reset to the round engine; 0 holds it idle.
- busy  out  1  match in progress.
- pwins  out  CNT_W  player round wins this match.
- dwins  out  CNT_W  dealer round wins this match.
- ties  out  CNT_W  tied rounds this match.
- round_count  out  CNT_W  rounds completed this match.
- match_over  out  1  match finished; results valid.
- match_player_win  out  1  player took the match.
- match_dealer_win  out  1  dealer took the match (both high means a drawn match).

Behaviour:
- Clocking and reset:
  - One clock, slow_clock.
  - resetb is asynchronous, active-low.
  - All outputs are registered.
- Reset values:
  - state = IDLE.
  - round_resetb = 0, busy = 0, match_over = 0, match_player_win = 0, match_dealer_win = 0.
  - pwins, dwins, ties, round_count = 0.
  - endround_q = 0.
- Edge detect:
  - endround_q <= endround on every posedge, in all states.
  - tally_ev = endround & ~endround_q. Each engine END state counts exactly once, however many posedges it spans.
- States:
  - IDLE: round_resetb = 0, busy = 0.
    - start_match = 1 -> clear all four counters, clear the match_* outputs, go to RUN.
  - RUN: round_resetb = 1, busy = 1.
    - abort = 1 -> IDLE. Counters hold their values; match_* stay 0. abort has priority over a tally_ev on the same edge, and that tally is discarded.
    - Otherwise, on tally_ev, update:
      - round_count += 1.
      - Both lights high: ties += 1.
      - Only player_win_light high: pwins += 1.
      - Only dealer_win_light high: dwins += 1.
      - Neither light high: no win counter changes; round_count still increments.
    - Match terminates if, after the update, pwins == WINS_TO_MATCH, or dwins == WINS_TO_MATCH, or round_count == MAX_ROUNDS.
      - On that same edge: go to DONE, round_resetb <= 0, match_over <= 1.
      - match_player_win <= (pwins_next >= dwins_next).
      - match_dealer_win <= (dwins_next >= pwins_next).
    - start_match is ignored in RUN.
  - DONE: round_resetb = 0, busy = 0, match_over = 1; counters and winner lights hold.
    - start_match = 1 -> clear counters and match_* outputs, go to RUN.
    - abort = 1 -> IDLE, counters held, match_* cleared.
    - If both start_match and abort are high, abort wins.
- Latency:
  - round_resetb rises on the edge that enters RUN; the engine starts its RST->PC1 sequence on its next active edge.
  - Counter outputs change on the posedge where tally_ev is true.
- Counters never wrap: the termination check guarantees none exceeds MAX_ROUNDS.
- Reset mid-match: all state is cleared asynchronously, and the engine is immediately held by round_resetb = 0.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Outcome encoding: {player_win_light, dealer_win_light} -> PLAYER = 2'b10, DEALER = 2'b01, TIE = 2'b11, NONE = 2'b00.
- One natural sub-module, round_tally: the edge detector plus the four counters, with clear and tally_ev inputs.
- The FSM and the termination compare stay in the top.

Test Plan:
- Reset, then start_match pulse -> round_resetb = 1 and busy = 1 after one posedge; all counters 0.
- Defaults; three rounds with player light only -> pwins = 3, round_count = 3, DONE, match_player_win = 1, match_dealer_win = 0, round_resetb = 0.
- endround held high for 4 posedges with dealer light -> dwins increments by exactly 1.
- MAX_ROUNDS = 9, nine tie rounds -> ties = 9, round_count = 9, match_over = 1, both match lights = 1.
- abort on the same edge as a tally_ev in RUN -> IDLE; counters unchanged by that round; match_over = 0.
- resetb low mid-RUN with pwins = 2 -> all outputs return to reset values asynchronously, without waiting for a clock edge; a subsequent start_match begins from zero.

Source files
------------

// File: rtl/baccarat_match_scheduler_pkg.sv
// Shared encodings for the baccarat match scheduler: FSM states and round outcomes.
package baccarat_match_scheduler_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // {player_win_light, dealer_win_light}
    localparam logic [1:0] OUT_NONE   = 2'b00;
    localparam logic [1:0] OUT_DEALER = 2'b01;
    localparam logic [1:0] OUT_PLAYER = 2'b10;
    localparam logic [1:0] OUT_TIE    = 2'b11;

endpackage

// File: rtl/baccarat_match_scheduler_round_tally.sv
// Endround edge detector and the four per-match tally counters.
module baccarat_match_scheduler_round_tally
    import baccarat_match_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             endround,
    input  logic             player_win_light,
    input  logic             dealer_win_light,
    input  logic             clear,
    input  logic             enable,
    output logic             tally_ev_c,
    output logic [CNT_W-1:0] pwins,
    output logic [CNT_W-1:0] dwins,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] round_count,
    output logic [CNT_W-1:0] pwins_next_c,
    output logic [CNT_W-1:0] dwins_next_c,
    output logic [CNT_W-1:0] round_count_next_c
);

    logic             endround_q;
    logic [CNT_W-1:0] ties_next_c;

    // A held endround counts once: only its rising edge is a tally event.
    assign tally_ev_c = endround & ~endround_q;

    always_comb begin
        pwins_next_c       = pwins;
        dwins_next_c       = dwins;
        ties_next_c        = ties;
        round_count_next_c = round_count + CNT_W'(1);
        case ({player_win_light, dealer_win_light})
            OUT_PLAYER: pwins_next_c = pwins + CNT_W'(1);
            OUT_DEALER: dwins_next_c = dwins + CNT_W'(1);
            OUT_TIE:    ties_next_c  = ties + CNT_W'(1);
            default:    ;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            endround_q  <= 1'b0;
            pwins       <= '0;
            dwins       <= '0;
            ties        <= '0;
            round_count <= '0;
        end else begin
            endround_q <= endround;
            if (clear) begin
                pwins       <= '0;
                dwins       <= '0;
                ties        <= '0;
                round_count <= '0;
            end else if (enable && tally_ev_c) begin
                pwins       <= pwins_next_c;
                dwins       <= dwins_next_c;
                ties        <= ties_next_c;
                round_count <= round_count_next_c;
            end
        end
    end

endmodule

// File: rtl/baccarat_match_scheduler.sv
// Best-of match sequencer around the baccarat round engine: tallies rounds, decides the match.
module baccarat_match_scheduler
    import baccarat_match_scheduler_pkg::*;
#(
    parameter int unsigned WINS_TO_MATCH = 3,
    parameter int unsigned MAX_ROUNDS    = 9,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             start_match,
    input  logic             abort,
    input  logic             endround,
    input  logic             player_win_light,
    input  logic             dealer_win_light,
    output logic             round_resetb,
    output logic             busy,
    output logic [CNT_W-1:0] pwins,
    output logic [CNT_W-1:0] dwins,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] round_count,
    output logic             match_over,
    output logic             match_player_win,
    output logic             match_dealer_win
);

    logic [1:0]       state, state_next;
    logic             clear_c, tally_en_c, tally_ev_c, finish_c;
    logic             match_over_next, mpw_next, mdw_next;
    logic [CNT_W-1:0] pwins_next_c, dwins_next_c, round_count_next_c;

    baccarat_match_scheduler_round_tally #(.CNT_W(CNT_W)) u_tally (
        .slow_clock         (slow_clock),
        .resetb             (resetb),
        .endround           (endround),
        .player_win_light   (player_win_light),
        .dealer_win_light   (dealer_win_light),
        .clear              (clear_c),
        .enable             (tally_en_c),
        .tally_ev_c         (tally_ev_c),
        .pwins              (pwins),
        .dwins              (dwins),
        .ties               (ties),
        .round_count        (round_count),
        .pwins_next_c       (pwins_next_c),
        .dwins_next_c       (dwins_next_c),
        .round_count_next_c (round_count_next_c)
    );

    // Termination is judged on the post-update counts of this round.
    assign finish_c = (pwins_next_c == CNT_W'(WINS_TO_MATCH)) ||
                      (dwins_next_c == CNT_W'(WINS_TO_MATCH)) ||
                      (round_count_next_c == CNT_W'(MAX_ROUNDS));

    always_comb begin
        state_next      = state;
        match_over_next = match_over;
        mpw_next        = match_player_win;
        mdw_next        = match_dealer_win;
        clear_c         = 1'b0;
        tally_en_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start_match) begin
                    state_next      = RUN;
                    clear_c         = 1'b1;
                    match_over_next = 1'b0;
                    mpw_next        = 1'b0;
                    mdw_next        = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    tally_en_c = 1'b1;
                    if (tally_ev_c && finish_c) begin
                        state_next      = DONE;
                        match_over_next = 1'b1;
                        mpw_next        = (pwins_next_c >= dwins_next_c);
                        mdw_next        = (dwins_next_c >= pwins_next_c);
                    end
                end
            end
            DONE: begin
                if (abort || start_match) begin
                    state_next      = abort ? IDLE : RUN;
                    clear_c         = ~abort;
                    match_over_next = 1'b0;
                    mpw_next        = 1'b0;
                    mdw_next        = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state            <= IDLE;
            round_resetb     <= 1'b0;
            busy             <= 1'b0;
            match_over       <= 1'b0;
            match_player_win <= 1'b0;
            match_dealer_win <= 1'b0;
        end else begin
            state            <= state_next;
            round_resetb     <= (state_next == RUN);
            busy             <= (state_next == RUN);
            match_over       <= match_over_next;
            match_player_win <= mpw_next;
            match_dealer_win <= mdw_next;
        end
    end

endmodule
